i2c_master_seq_ctrl: RTL and testbench

//  Master-side sequencer for i2c_data_path_block: owns the SCL phase counter, drives the one-hot

---
 rtl/i2c_pkg.sv | 23 ++
 rtl/i2c_scl_gen.sv | 44 ++++
 rtl/i2c_master_seq_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_i2c_master_seq_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C master sequencer and its SCL phase generator.
package i2c_pkg;

   typedef enum logic [3:0] {
      StIdle,
      StStart,
      StWrAddr,
      StAddrAck,
      StWrData,
      StDataAck,
      StRdData,
      StMstAck,
      StStop,
      StRepStart
   } state_e;

   localparam int unsigned PrescalerMinDefault = 2;
   // Phase counter is one bit wider than the 8-bit prescaler so 2P-1 always fits.
   localparam int unsigned CntW = 9;
   localparam logic AckBit  = 1'b0;
   localparam logic NackBit = 1'b1;

endpackage

// File: rtl/i2c_scl_gen.sv
// SCL phase counter: counts 0..2P-1 per bit period, holds at 0 while frozen or idle.
module i2c_scl_gen
   import i2c_pkg::*;
(
   input  logic            i2c_core_clock_i,
   input  logic            reset_bit_i,
   input  logic            run,
   input  logic            freeze,
   input  logic [7:0]      half,
   output logic [CntW-1:0] count,
   output logic            scl_high,
   output logic            bit_end
);

   logic [CntW-1:0] count_q, count_d, last;

   assign last = {half, 1'b0} - CntW'(1);

   always_comb begin
      count_d = count_q;
      if (!run) begin
         count_d = '0;
      end else if (freeze) begin
         count_d = count_q;
      end else if (count_q == last) begin
         count_d = '0;
      end else begin
         count_d = count_q + CntW'(1);
      end
   end

   always_ff @(posedge i2c_core_clock_i or negedge reset_bit_i) begin
      if (!reset_bit_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count    = count_q;
   assign bit_end  = (count_q == last);
   assign scl_high = (count_q >= {1'b0, half});

endmodule

// File: rtl/i2c_master_seq_ctrl.sv
// Master-side I2C sequencer: turns a host command into phase strobes, bit/byte tracking,
// ACK/NACK handling, repeated start and write-data clock stretching.
module i2c_master_seq_ctrl
   import i2c_pkg::*;
#(
   parameter int unsigned PRESCALER_MIN = PrescalerMinDefault,
   parameter int unsigned BYTE_CNT_W    = 8
) (
   input  logic                  i2c_core_clock_i,
   input  logic                  reset_bit_i,
   input  logic                  enable_i,
   input  logic                  start_i,
   input  logic [7:0]            addr_rw_i,
   input  logic [BYTE_CNT_W-1:0] num_bytes_i,
   input  logic                  rep_start_i,
   input  logic [7:0]            prescaler_i,
   input  logic                  tx_valid_i,
   input  logic                  sda_i,
   output logic                  start_cnt_o,
   output logic                  write_addr_cnt_o,
   output logic                  write_data_cnt_o,
   output logic                  read_data_cnt_o,
   output logic                  write_ack_cnt_o,
   output logic                  read_ack_cnt_o,
   output logic                  stop_cnt_o,
   output logic                  repeat_start_cnt_o,
   output logic [7:0]            counter_detect_edge_o,
   output logic                  scl_o,
   output logic                  ack_bit_o,
   output logic                  tx_req_o,
   output logic                  rx_valid_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  nack_o
);

   state_e                state_q, state_d;
   logic [2:0]            bit_cnt_q, bit_cnt_d;
   logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d, num_q, num_d, byte_dec;
   logic [7:0]            presc_q, presc_d, presc_in;
   logic                  rw_q, rw_d, nack_q, nack_d, done_q, done_d;
   logic                  busy, freeze, bit_end, scl_high, byte_state, last_byte, last_bit;
   logic [CntW-1:0]       count;

   // Only the rw bit steers sequencing; the address itself is shifted by the datapath.
   logic unused_addr;
   assign unused_addr = ^addr_rw_i[7:1];

   assign busy       = (state_q != StIdle);
   assign byte_state = (state_q == StWrAddr) || (state_q == StWrData) || (state_q == StRdData);
   assign last_bit   = bit_end && (bit_cnt_q == 3'd0);
   assign last_byte  = (byte_cnt_q <= BYTE_CNT_W'(1));
   assign byte_dec   = (byte_cnt_q == '0) ? '0 : byte_cnt_q - BYTE_CNT_W'(1);
   assign presc_in   = (prescaler_i < 8'(PRESCALER_MIN)) ? 8'(PRESCALER_MIN) : prescaler_i;
   // Stretch SCL low before the first bit of a write byte until the datapath has data.
   assign freeze     = (state_q == StWrData) && (bit_cnt_q == 3'd7) && (count == '0) &&
                       !tx_valid_i;

   i2c_scl_gen u_scl_gen (
      .i2c_core_clock_i (i2c_core_clock_i),
      .reset_bit_i      (reset_bit_i),
      .run              (busy),
      .freeze           (freeze),
      .half             (presc_q),
      .count            (count),
      .scl_high         (scl_high),
      .bit_end          (bit_end)
   );

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      byte_cnt_d = byte_cnt_q;
      num_d      = num_q;
      rw_d       = rw_q;
      presc_d    = presc_q;
      nack_d     = nack_q;
      done_d     = 1'b0;

      if (bit_end) begin
         bit_cnt_d = byte_state ? bit_cnt_q - 3'd1 : 3'd7;
      end

      unique case (state_q)
         StIdle: begin
            if (start_i && enable_i) begin
               state_d    = StStart;
               rw_d       = addr_rw_i[0];
               num_d      = num_bytes_i;
               byte_cnt_d = num_bytes_i;
               presc_d    = presc_in;
               nack_d     = 1'b0;
            end
         end
         StStart: if (bit_end) state_d = StWrAddr;
         StWrAddr: if (last_bit) state_d = StAddrAck;
         StAddrAck: begin
            if (bit_end) begin
               if (sda_i == NackBit) begin
                  state_d = StStop;
                  nack_d  = 1'b1;
               end else if (byte_cnt_q == '0) begin
                  state_d = StStop;
               end else begin
                  state_d = rw_q ? StRdData : StWrData;
               end
            end
         end
         StWrData: if (last_bit) state_d = StDataAck;
         StDataAck: begin
            if (bit_end) begin
               byte_cnt_d = byte_dec;
               if (sda_i == NackBit) begin
                  state_d = StStop;
                  nack_d  = 1'b1;
               end else if (!last_byte) begin
                  state_d = StWrData;
               end else begin
                  state_d = rep_start_i ? StRepStart : StStop;
               end
            end
         end
         StRdData: if (last_bit) state_d = StMstAck;
         StMstAck: begin
            if (bit_end) begin
               byte_cnt_d = byte_dec;
               if (!last_byte) begin
                  state_d = StRdData;
               end else begin
                  state_d = rep_start_i ? StRepStart : StStop;
               end
            end
         end
         StStop: begin
            if (bit_end) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         StRepStart: begin
            if (start_i) begin
               rw_d   = addr_rw_i[0];
               num_d  = num_bytes_i;
               nack_d = 1'b0;
            end
            if (bit_end) begin
               state_d    = StStart;
               byte_cnt_d = num_d;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i2c_core_clock_i or negedge reset_bit_i) begin
      if (!reset_bit_i) begin
         state_q    <= StIdle;
         bit_cnt_q  <= 3'd7;
         byte_cnt_q <= '0;
         num_q      <= '0;
         rw_q       <= 1'b0;
         presc_q    <= 8'(PRESCALER_MIN);
         nack_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         num_q      <= num_d;
         rw_q       <= rw_d;
         presc_q    <= presc_d;
         nack_q     <= nack_d;
         done_q     <= done_d;
      end
   end

   assign start_cnt_o           = (state_q == StStart);
   assign write_addr_cnt_o      = (state_q == StWrAddr);
   assign write_data_cnt_o      = (state_q == StWrData);
   assign read_data_cnt_o       = (state_q == StRdData);
   assign write_ack_cnt_o       = (state_q == StMstAck);
   assign read_ack_cnt_o        = (state_q == StAddrAck) || (state_q == StDataAck);
   assign stop_cnt_o            = (state_q == StStop);
   assign repeat_start_cnt_o    = (state_q == StRepStart);
   assign counter_detect_edge_o = count[7:0];
   assign scl_o                 = ((state_q == StIdle) || (state_q == StStart)) ? 1'b1 : scl_high;
   assign ack_bit_o             = ((state_q == StMstAck) && last_byte) ? NackBit : AckBit;
   assign tx_req_o              = (state_q == StDataAck) && bit_end;
   assign rx_valid_o            = (state_q == StRdData) && last_bit;
   assign busy_o                = busy;
   assign done_o                = done_q;
   assign nack_o                = nack_q;

endmodule

// File: tb/tb_i2c_master_seq_ctrl.sv
// Scoreboard bench: a timeline model predicts phase entries and pulses per command,
// a negedge monitor pops and compares every event the sequencer presents.
module tb_i2c_master_seq_ctrl;

   localparam int C_START = 0, C_WADDR = 1, C_WDATA = 2, C_RDATA = 3, C_MACK = 4,
                  C_RDACK = 5, C_STOP = 6, C_REP = 7, C_TXREQ = 10, C_RXV = 11,
                  C_DONE = 12, C_STALL = 13;

   typedef struct {
      int code;
      int cyc;
      int aux;
   } token_t;

   typedef struct {
      bit       rw;
      bit [6:0] addr;
      int       num;
      int       presc;
      int       nack_at;
      bit       rep;
      int       stall_b;
      int       stall_s;
   } cmd_t;

   logic       clk, rst_n, enable, start, rep_start, tx_valid, sda;
   logic [7:0] addr_rw, num_bytes, prescaler, counter;
   logic       s_start, s_waddr, s_wdata, s_rdata, s_wack, s_rack, s_stop, s_rep;
   logic       scl, ack_bit, tx_req, rx_valid, busy, done, nack;
   logic [7:0] strobes;

   int     cyc = 0;
   int     errors = 0;
   int     checks = 0;
   token_t exp_q[$];
   int     nack_at = -1;
   int     ack_idx = 0;
   logic   resp_prev_start = 1'b0, resp_prev_rack = 1'b0;
   logic [7:0] mon_prev = '0;
   int     mon_run = 0;
   int     mon_code;

   i2c_master_seq_ctrl #(
      .PRESCALER_MIN (2),
      .BYTE_CNT_W    (8)
   ) dut (
      .i2c_core_clock_i      (clk),
      .reset_bit_i           (rst_n),
      .enable_i              (enable),
      .start_i               (start),
      .addr_rw_i             (addr_rw),
      .num_bytes_i           (num_bytes),
      .rep_start_i           (rep_start),
      .prescaler_i           (prescaler),
      .tx_valid_i            (tx_valid),
      .sda_i                 (sda),
      .start_cnt_o           (s_start),
      .write_addr_cnt_o      (s_waddr),
      .write_data_cnt_o      (s_wdata),
      .read_data_cnt_o       (s_rdata),
      .write_ack_cnt_o       (s_wack),
      .read_ack_cnt_o        (s_rack),
      .stop_cnt_o            (s_stop),
      .repeat_start_cnt_o    (s_rep),
      .counter_detect_edge_o (counter),
      .scl_o                 (scl),
      .ack_bit_o             (ack_bit),
      .tx_req_o              (tx_req),
      .rx_valid_o            (rx_valid),
      .busy_o                (busy),
      .done_o                (done),
      .nack_o                (nack)
   );

   assign strobes = {s_rep, s_stop, s_rack, s_wack, s_rdata, s_wdata, s_waddr, s_start};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int clamp_p(input int p);
      return (p < 2) ? 2 : p;
   endfunction

   task automatic put(input int code, input int t, input int aux, input int cut);
      token_t tk;
      tk.code = code;
      tk.cyc  = t;
      tk.aux  = aux;
      if (t < cut) exp_q.push_back(tk);
   endtask

   // Timeline of one command: START, 8 address bits, ACK, per-byte 8 bits + ACK, then STOP
   // or REP_START followed by a second identical segment.
   task automatic model_txn(input cmd_t c, input int t0, input int cut, output int t_end,
                            output int stall_e, output int rep_t);
      int  t, p;
      bit  nk, more;
      p       = clamp_p(c.presc);
      t       = t0;
      stall_e = -10;
      rep_t   = -10;
      for (int seg = 0; seg < 2; seg++) begin
         nk   = 1'b0;
         more = 1'b0;
         put(C_START, t, 2, cut);
         t += 2 * p;
         put(C_WADDR, t, 0, cut);
         t += 16 * p;
         put(C_RDACK, t, 0, cut);
         t += 2 * p;
         if (c.nack_at == 0 && seg == 0) begin
            nk = 1'b1;
         end else begin
            for (int b = 0; b < c.num; b++) begin
               if (!c.rw) begin
                  put(C_WDATA, t, 0, cut);
                  if (seg == 0 && b == c.stall_b && c.stall_s > 0) begin
                     stall_e = t;
                     put(C_STALL, t + c.stall_s + 1, c.stall_s + 1, cut);
                     t += c.stall_s;
                  end
                  t += 16 * p;
                  put(C_RDACK, t, 0, cut);
                  t += 2 * p;
                  put(C_TXREQ, t - 1, 0, cut);
                  if (seg == 0 && c.nack_at == b + 1) begin
                     nk = 1'b1;
                     break;
                  end
               end else begin
                  put(C_RDATA, t, 0, cut);
                  t += 16 * p;
                  put(C_RXV, t - 1, 0, cut);
                  put(C_MACK, t, (b == c.num - 1) ? 1 : 0, cut);
                  t += 2 * p;
               end
            end
         end
         if (!nk && c.num > 0 && c.rep && seg == 0) begin
            put(C_REP, t, 0, cut);
            rep_t = t;
            t += 2 * p;
            more = 1'b1;
         end else begin
            put(C_STOP, t, 0, cut);
            t += 2 * p;
            put(C_DONE, t, nk ? 1 : 0, cut);
         end
         if (!more) break;
      end
      t_end = t;
   endtask

   task automatic got(input int code, input int aux);
      token_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL event_unexpected: got code=%0d cyc=%0d aux=%0d, required none", code,
                  cyc, aux);
      end else begin
         e = exp_q.pop_front();
         if (e.code != code || e.cyc != cyc || e.aux != aux) begin
            errors++;
            $display("FAIL event: got code=%0d cyc=%0d aux=%0d, required code=%0d cyc=%0d aux=%0d",
                     code, cyc, aux, e.code, e.cyc, e.aux);
         end
      end
   endtask

   task automatic check_reset_outputs(input string name);
      logic [21:0] act;
      act = {strobes, counter, scl, ack_bit, tx_req, rx_valid, busy, done, nack};
      checks++;
      if (act !== {8'h00, 8'h00, 1'b1, 5'b0, 1'b0}) begin
         errors++;
         $display("FAIL %s: got %b, required %b", name, act, {8'h00, 8'h00, 1'b1, 6'b0});
      end
   endtask

   // Slave responder: drives the ACK bit for each ACK-read phase of the current command.
   always @(negedge clk) begin
      if (s_start && !resp_prev_start) ack_idx = 0;
      if (s_rack && !resp_prev_rack) begin
         sda = (ack_idx == nack_at) ? 1'b1 : 1'b0;
         ack_idx++;
      end
      resp_prev_start = s_start;
      resp_prev_rack  = s_rack;
   end

   // Monitor: one event per phase entry, per pulse, and per write-stretch run.
   always @(negedge clk) begin
      if (!rst_n) begin
         mon_prev = '0;
         mon_run  = 0;
      end else begin
         checks++;
         if (!$onehot0(strobes)) begin
            errors++;
            $display("FAIL strobe_onehot: got %b, required at most one bit set", strobes);
         end
         if (strobes != mon_prev && strobes != 8'h00) begin
            mon_code = 0;
            for (int i = 0; i < 8; i++) if (strobes[i]) mon_code = i;
            if (mon_code == C_START) got(mon_code, int'({busy, nack}));
            else if (mon_code == C_MACK) got(mon_code, int'(ack_bit));
            else got(mon_code, 0);
         end
         if (tx_req) got(C_TXREQ, 0);
         if (rx_valid) got(C_RXV, 0);
         if (done) got(C_DONE, int'({busy, nack}));
         if (s_wdata && counter == 8'h00 && !scl) begin
            mon_run++;
         end else begin
            if (mon_run > 1) got(C_STALL, mon_run);
            mon_run = 0;
         end
         mon_prev = strobes;
      end
   end

   function automatic cmd_t mk(input bit rw, input bit [6:0] addr, input int num,
                               input int presc, input int nk, input bit rep,
                               input int sb, input int ss);
      cmd_t c;
      c.rw = rw; c.addr = addr; c.num = num; c.presc = presc; c.nack_at = nk;
      c.rep = rep; c.stall_b = sb; c.stall_s = ss;
      return c;
   endfunction

   task automatic run_txn(input cmd_t c, input bit do_reset);
      int t0, t_end, stall_e, rep_t, cut, stop_at;
      @(negedge clk);
      t0  = cyc;
      cut = do_reset ? t0 + 1 + 20 * clamp_p(c.presc) + 5 : 32'h3fff_ffff;
      model_txn(c, t0 + 1, cut, t_end, stall_e, rep_t);
      nack_at   = c.nack_at;
      addr_rw   = {c.addr, c.rw};
      num_bytes = 8'(c.num);
      prescaler = 8'(c.presc);
      rep_start = c.rep;
      start     = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      stop_at = do_reset ? cut : t_end + 3;
      while (cyc < stop_at) begin
         if (cyc == t0 + 4) begin
            prescaler = 8'($urandom);
            enable    = 1'b0;
         end
         if (cyc == t0 + 6) start = 1'b1;
         if (cyc == t0 + 7) start = 1'b0;
         if (cyc == t0 + 8) enable = 1'b1;
         if (cyc == stall_e - 1) tx_valid = 1'b0;
         if (cyc == stall_e + c.stall_s) tx_valid = 1'b1;
         if (cyc == rep_t) rep_start = 1'b0;
         @(negedge clk);
      end
      if (do_reset) begin
         rst_n = 1'b0;
         #1;
         check_reset_outputs("reset_mid_read");
         repeat (3) @(negedge clk);
         rst_n = 1'b1;
      end
      rep_start = 1'b0;
      tx_valid  = 1'b1;
   endtask

   initial begin
      cmd_t c;
      int   num, rr;
      rst_n     = 1'b0;
      enable    = 1'b1;
      start     = 1'b0;
      addr_rw   = 8'h00;
      num_bytes = 8'h00;
      rep_start = 1'b0;
      prescaler = 8'd4;
      tx_valid  = 1'b1;
      sda       = 1'b1;
      #1;
      check_reset_outputs("reset_state");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      run_txn(mk(1'b0, 7'h50, 2, 4, -1, 1'b0, -1, 0), 1'b0);  // plain write
      run_txn(mk(1'b1, 7'h50, 3, 4, -1, 1'b0, -1, 0), 1'b0);  // read 0xA1
      run_txn(mk(1'b0, 7'h50, 2, 4, 0, 1'b0, -1, 0), 1'b0);   // address NACK
      run_txn(mk(1'b0, 7'h50, 3, 4, -1, 1'b0, 1, 20), 1'b0);  // stretch on byte 2
      run_txn(mk(1'b0, 7'h50, 1, 4, -1, 1'b1, -1, 0), 1'b0);  // repeated start
      run_txn(mk(1'b0, 7'h22, 3, 3, 2, 1'b0, -1, 0), 1'b0);   // data NACK
      run_txn(mk(1'b1, 7'h11, 1, 0, -1, 1'b0, -1, 0), 1'b0);  // prescaler clamp
      run_txn(mk(1'b0, 7'h33, 0, 2, -1, 1'b1, -1, 0), 1'b0);  // zero-byte command

      // Disabled block ignores start.
      @(negedge clk);
      enable = 1'b0;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (40) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL disabled_start: got busy=%b, required 0", busy);
      end
      enable = 1'b1;

      run_txn(mk(1'b1, 7'h50, 3, 4, -1, 1'b0, -1, 0), 1'b1);  // reset during RD_DATA

      for (int n = 0; n < 20; n++) begin
         c.rw      = 1'($urandom);
         c.addr    = 7'($urandom);
         num       = $urandom_range(0, 3);
         c.num     = num;
         c.presc   = $urandom_range(0, 5);
         rr        = $urandom_range(0, 5);
         c.nack_at = -1;
         if (rr == 0) c.nack_at = c.rw ? 0 : $urandom_range(0, num);
         c.rep     = ($urandom_range(0, 4) == 0);
         c.stall_b = -1;
         c.stall_s = 0;
         if (!c.rw && num > 0 && $urandom_range(0, 2) == 0) begin
            c.stall_b = $urandom_range(0, num - 1);
            c.stall_s = $urandom_range(1, 12);
         end
         run_txn(c, 1'b0);
      end

      repeat (5) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL queue_drained: got %0d pending events, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
